// File: rtl/cram_loader.sv
// cram_loader
//   Configuration bitstream loader for the fabric CRAM shift chain. Takes
//   bitstream words over a valid/ready stream, serialises them MSB-first onto
//   the chain input at one bit per cycle, frames the load to exactly
//   CHAIN_LENGTH bits, then accepts 16/WORD_WIDTH trailing CRC words and
//   compares them against a CRC-16/CCITT-FALSE of the bits actually shifted.
//
// Ports
//   clk             in   clock (also clocks the CRAM chain)
//   rst             in   synchronous active-high reset
//   start           in   begin a load (only honoured while idle)
//   word_in         in   bitstream word, WORD_WIDTH bits
//   word_valid      in   word_in is valid
//   word_ready      out  loader accepts word_in this cycle
//   config_data_out out  serial bit to the chain's config_data_in
//   config_en       out  chain shift enable, high only when a real bit is presented
//   busy            out  load in progress
//   done            out  one-cycle pulse at the end of a load
//   crc_error       out  CRC mismatch on the last load, held until next start
module cram_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_data_out,
  output logic                  config_en,
  output logic                  busy,
  output logic                  done,
  output logic                  crc_error
);

  localparam int CRC_WORDS = 16 / WORD_WIDTH;
  localparam int MAX_LEN   = (CHAIN_LENGTH > WORD_WIDTH) ? CHAIN_LENGTH : WORD_WIDTH;
  localparam int CNT_W     = $clog2(MAX_LEN + 1);
  localparam int SCNT_W    = $clog2(WORD_WIDTH + 1);
  localparam int CRCW_W    = $clog2(CRC_WORDS + 1);

  localparam logic [CNT_W-1:0]  CHAIN_LEN_C = CNT_W'(CHAIN_LENGTH);
  localparam logic [CNT_W-1:0]  LAST_BIT_C  = CNT_W'(CHAIN_LENGTH - 1);
  localparam logic [CNT_W-1:0]  WORD_W_C    = CNT_W'(WORD_WIDTH);
  localparam logic [SCNT_W-1:0] WORD_W_S    = SCNT_W'(WORD_WIDTH);
  localparam logic [SCNT_W-1:0] SCNT_ONE    = SCNT_W'(1);
  localparam logic [CRCW_W-1:0] LAST_CRCW_C = CRCW_W'(CRC_WORDS - 1);
  localparam logic [CRCW_W-1:0] CRCW_ONE    = CRCW_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [15:0]       CRC_POLY    = 16'h1021;
  localparam logic [15:0]       CRC_INIT    = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE
  } state_t;

  state_t              state;
  logic [WORD_WIDTH-1:0] sreg;       // word being shifted, MSB is the current bit
  logic [SCNT_W-1:0]   sreg_cnt;     // valid bits still held in sreg
  logic [CNT_W-1:0]    bit_cnt;      // bits shifted onto the chain this load
  logic [CNT_W-1:0]    taken_cnt;    // bits accepted into sreg this load
  logic [CRCW_W-1:0]   crcw_cnt;     // CRC words accepted so far
  logic [15:0]         crc;
  logic [15:0]         crc_exp;
  logic                crc_error_q;

  logic                shifting;
  logic                xfer;
  logic [CNT_W-1:0]    remaining;
  logic [SCNT_W-1:0]   take_bits;
  logic [15:0]         crc_shifted;
  logic [15:0]         crc_exp_next;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ (((c[15] ^ b) == 1'b1) ? CRC_POLY : 16'h0000);
  endfunction

  always_comb begin
    shifting     = (state == S_LOAD) && (sreg_cnt != '0);
    remaining    = CHAIN_LEN_C - taken_cnt;
    // The final data word only contributes the bits still needed by the chain.
    take_bits    = (remaining >= WORD_W_C) ? WORD_W_S : SCNT_W'(remaining);
    crc_shifted  = crc_step(crc, sreg[WORD_WIDTH-1]);
    // Expected CRC accumulates first word most significant; the concatenation
    // truncated to 16 bits drops the oldest bits (empty for one-word CRCs).
    crc_exp_next = 16'({crc_exp, word_in});

    word_ready = 1'b0;
    case (state)
      // Ready while empty or while the last held bit is leaving, so a
      // continuous stream loads without a bubble.
      S_LOAD:  word_ready = (taken_cnt != CHAIN_LEN_C) && (sreg_cnt <= SCNT_ONE);
      S_CHECK: word_ready = 1'b1;
      default: word_ready = 1'b0;
    endcase
    xfer = word_valid && word_ready;
  end

  assign config_en       = shifting;
  assign config_data_out = shifting & sreg[WORD_WIDTH-1];
  assign busy            = (state != S_IDLE);
  assign done            = (state == S_DONE);
  assign crc_error       = crc_error_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      sreg        <= '0;
      sreg_cnt    <= '0;
      bit_cnt     <= '0;
      taken_cnt   <= '0;
      crcw_cnt    <= '0;
      crc         <= '0;
      crc_exp     <= '0;
      crc_error_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_LOAD;
            sreg        <= '0;
            sreg_cnt    <= '0;
            bit_cnt     <= '0;
            taken_cnt   <= '0;
            crcw_cnt    <= '0;
            crc         <= CRC_INIT;
            crc_exp     <= '0;
            crc_error_q <= 1'b0;
          end
        end

        S_LOAD: begin
          if (shifting) begin
            sreg     <= sreg << 1;
            sreg_cnt <= sreg_cnt - SCNT_ONE;
            crc      <= crc_shifted;
            bit_cnt  <= bit_cnt + CNT_ONE;
            if (bit_cnt == LAST_BIT_C) begin
              state <= S_CHECK;
            end
          end
          // A transfer only happens when sreg is empty or on its last bit,
          // so the new word simply replaces whatever the shift left behind.
          if (xfer) begin
            sreg      <= word_in;
            sreg_cnt  <= take_bits;
            taken_cnt <= taken_cnt + CNT_W'(take_bits);
          end
        end

        S_CHECK: begin
          if (xfer) begin
            crc_exp  <= crc_exp_next;
            crcw_cnt <= crcw_cnt + CRCW_ONE;
            if (crcw_cnt == LAST_CRCW_C) begin
              crc_error_q <= (crc != crc_exp_next);
              state       <= S_DONE;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          sreg  <= '0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cram_loader.sv
// Bench for cram_loader: four instances with different word widths and chain
// lengths, driven one at a time, each checked every cycle against a
// bit-accounting model (bits accepted vs bits shifted, CRC over the bits the
// chain should have received), plus literal expectations for known vectors.
module tb_cram_loader;

  localparam int NI = 4;

  function automatic int ww(input int i);
    return (i == 2) ? 16 : 8;
  endfunction

  function automatic int cl(input int i);
    case (i)
      0:       return 12;
      1:       return 72;
      2:       return 16;
      default: return 8;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]       rst_v;
  logic [NI-1:0]       start_v;
  logic [NI-1:0]       valid_v;
  logic [NI-1:0][15:0] word_v;
  wire  [NI-1:0]       ready_v;
  wire  [NI-1:0]       cdo_v;
  wire  [NI-1:0]       cen_v;
  wire  [NI-1:0]       busy_v;
  wire  [NI-1:0]       done_v;
  wire  [NI-1:0]       err_v;

  cram_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(12)) u_l12 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .word_in(word_v[0][7:0]),
    .word_valid(valid_v[0]), .word_ready(ready_v[0]), .config_data_out(cdo_v[0]),
    .config_en(cen_v[0]), .busy(busy_v[0]), .done(done_v[0]), .crc_error(err_v[0]));

  cram_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(72)) u_l72 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .word_in(word_v[1][7:0]),
    .word_valid(valid_v[1]), .word_ready(ready_v[1]), .config_data_out(cdo_v[1]),
    .config_en(cen_v[1]), .busy(busy_v[1]), .done(done_v[1]), .crc_error(err_v[1]));

  cram_loader #(.WORD_WIDTH(16), .CHAIN_LENGTH(16)) u_w16 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .word_in(word_v[2]),
    .word_valid(valid_v[2]), .word_ready(ready_v[2]), .config_data_out(cdo_v[2]),
    .config_en(cen_v[2]), .busy(busy_v[2]), .done(done_v[2]), .crc_error(err_v[2]));

  cram_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(8)) u_l8 (
    .clk(clk), .rst(rst_v[3]), .start(start_v[3]), .word_in(word_v[3][7:0]),
    .word_valid(valid_v[3]), .word_ready(ready_v[3]), .config_data_out(cdo_v[3]),
    .config_en(cen_v[3]), .busy(busy_v[3]), .done(done_v[3]), .crc_error(err_v[3]));

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Model state per instance
  int          m_phase [NI];   // 0 idle, 1 load, 2 check, 3 done
  int          m_avail [NI];   // chain bits delivered by accepted words
  int          m_shift [NI];   // chain bits shifted so far
  int          m_crcw  [NI];
  logic [15:0] m_exp   [NI];
  bit          m_err   [NI];
  bit          m_bits  [NI][128];

  // Observations for literal checks
  int           obs_en_cnt [NI];
  int           obs_first  [NI];
  int           obs_last   [NI];
  int           obs_done   [NI];
  logic [127:0] obs_vec    [NI];

  logic [15:0] wq[$];

  function automatic void cmp(input string nm, input int i, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0b want=%0b", nm, i, cyc, a, e);
    end
  endfunction

  function automatic void chk_lit(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", nm, a, e);
    end
  endfunction

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input bit b);
    logic [15:0] r;
    r = {c[14:0], 1'b0};
    if ((c[15] ^ b) == 1'b1) r = r ^ 16'h1021;
    return r;
  endfunction

  function automatic logic [15:0] crc_of_bits(input int i, input int n);
    logic [15:0] c = 16'hFFFF;
    for (int k = 0; k < n; k++) c = crc_upd(c, m_bits[i][k]);
    return c;
  endfunction

  // CRC of the first l chain bits carried by the words in wq
  function automatic logic [15:0] crc_of_queue(input int w, input int l);
    logic [15:0] c = 16'hFFFF;
    logic [15:0] wd;
    int n = 0;
    foreach (wq[k]) begin
      wd = wq[k];
      for (int b = w - 1; b >= 0; b--) begin
        if (n < l) begin
          c = crc_upd(c, wd[b]);
          n++;
        end
      end
    end
    return c;
  endfunction

  task automatic model_step(input int i);
    int w = ww(i);
    int l = cl(i);
    int n;
    logic [15:0] wd;
    logic [15:0] mask;
    logic e_en, e_rdy;
    mask  = 16'((32'h1 << w) - 1);
    e_en  = (m_phase[i] == 1) && (m_avail[i] > m_shift[i]);
    e_rdy = ((m_phase[i] == 1) && (m_avail[i] < l) && (m_avail[i] - m_shift[i] <= 1))
            || (m_phase[i] == 2);
    if (chk_en) begin
      cmp("busy", i, busy_v[i], m_phase[i] != 0);
      cmp("done", i, done_v[i], m_phase[i] == 3);
      cmp("crc_error", i, err_v[i], m_err[i]);
      cmp("config_en", i, cen_v[i], e_en);
      cmp("word_ready", i, ready_v[i], e_rdy);
      if (e_en && cen_v[i]) cmp("data", i, cdo_v[i], m_bits[i][m_shift[i]]);
      if (cen_v[i]) begin
        obs_vec[i] = {obs_vec[i][126:0], cdo_v[i]};
        if (obs_en_cnt[i] == 0) obs_first[i] = cyc;
        obs_last[i] = cyc;
        obs_en_cnt[i]++;
      end
      if (done_v[i]) obs_done[i]++;
    end
    wd = word_v[i];
    if (rst_v[i]) begin
      m_phase[i] = 0;
      m_err[i]   = 1'b0;
    end else begin
      case (m_phase[i])
        0: if (start_v[i]) begin
          m_phase[i] = 1; m_avail[i] = 0; m_shift[i] = 0;
          m_crcw[i] = 0; m_exp[i] = '0; m_err[i] = 1'b0;
          obs_en_cnt[i] = 0; obs_vec[i] = '0; obs_first[i] = 0; obs_last[i] = 0;
        end
        1: begin
          if (e_en) m_shift[i]++;
          if (valid_v[i] && e_rdy) begin
            n = (l - m_avail[i] < w) ? l - m_avail[i] : w;
            for (int b = 0; b < n; b++) m_bits[i][m_avail[i] + b] = wd[w - 1 - b];
            m_avail[i] += n;
          end
          if (m_shift[i] == l) m_phase[i] = 2;
        end
        2: if (valid_v[i]) begin
          m_exp[i] = 16'((32'(m_exp[i]) << w) | 32'(wd & mask));
          m_crcw[i]++;
          if (m_crcw[i] == 16 / w) begin
            m_err[i]   = (crc_of_bits(i, l) != m_exp[i]);
            m_phase[i] = 3;
          end
        end
        default: m_phase[i] = 0;
      endcase
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < NI; i++) model_step(i);
  end

  task automatic send_word(input int i, input logic [15:0] w, input int gapmax);
    bit got = 1'b0;
    repeat ($urandom_range(0, gapmax)) begin
      @(posedge clk); #1;
    end
    valid_v[i] = 1'b1;
    word_v[i]  = w;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      got = ready_v[i];
      @(posedge clk); #1;
    end
    valid_v[i] = 1'b0;
    if (!got) chk_lit("word_accept_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int i);
    bit idle = 1'b0;
    for (int t = 0; t < 100 && !idle; t++) begin
      @(negedge clk);
      idle = !busy_v[i];
    end
    @(posedge clk); #1;
    if (!idle) chk_lit("idle_timeout", 0, 1);
  endtask

  task automatic run_load(input int i, input int gapmax, input bit mid_start);
    start_v[i] = 1'b1;
    @(posedge clk); #1;
    start_v[i] = 1'b0;
    foreach (wq[k]) begin
      send_word(i, wq[k], gapmax);
      if (k == 0 && mid_start) begin
        start_v[i] = 1'b1;
        @(posedge clk); #1;
        start_v[i] = 1'b0;
      end
    end
    wait_idle(i);
  endtask

  // Random data words for instance i followed by a good or corrupted CRC
  task automatic build_random(input int i, input bit bad);
    int w = ww(i);
    int l = cl(i);
    logic [15:0] mask;
    logic [15:0] c;
    mask = 16'((32'h1 << w) - 1);
    wq.delete();
    for (int k = 0; k < (l + w - 1) / w; k++) wq.push_back(16'($urandom) & mask);
    c = crc_of_queue(w, l);
    if (bad) c = c ^ 16'(32'h1 << $urandom_range(0, 15));
    for (int k = 0; k < 16 / w; k++) wq.push_back(16'(int'(c) >> (16 - w * (k + 1))) & mask);
  endtask

  initial begin
    int d;
    bit bad;
    logic [15:0] good;
    rst_v   = '1;
    start_v = '0;
    valid_v = '0;
    word_v  = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst_v = '0;
    @(posedge clk); #1;

    // CL=8: one zero byte, CRC 0xE1F0 good, then 0xE1F1 bad
    d  = obs_done[3];
    wq = '{16'h00, 16'hE1, 16'hF0};
    run_load(3, 0, 1'b0);
    chk_lit("l8_en_cnt", obs_en_cnt[3], 8);
    chk_lit("l8_contig", obs_last[3] - obs_first[3] + 1, 8);
    chk_lit("l8_bits", int'(obs_vec[3][7:0]), 0);
    chk_lit("l8_crc_ok", int'(err_v[3]), 0);
    chk_lit("l8_done_cnt", obs_done[3], d + 1);
    wq = '{16'h00, 16'hE1, 16'hF1};
    run_load(3, 0, 1'b0);
    chk_lit("l8_crc_bad", int'(err_v[3]), 1);

    // CL=72: "123456789" with check value 0x29B1
    wq = '{16'h31, 16'h32, 16'h33, 16'h34, 16'h35, 16'h36, 16'h37, 16'h38, 16'h39,
           16'h29, 16'hB1};
    run_load(1, 0, 1'b0);
    chk_lit("l72_en_cnt", obs_en_cnt[1], 72);
    chk_lit("l72_contig", obs_last[1] - obs_first[1] + 1, 72);
    chk_lit("l72_crc_ok", int'(err_v[1]), 0);

    // CL=12: 0xA5, 0x3C -> 12 bits 1010_0101_0011, low nibble of 0x3C dropped
    wq = '{16'hA5, 16'h3C};
    good = crc_of_queue(8, 12);
    wq.push_back({8'h00, good[15:8]});
    wq.push_back({8'h00, good[7:0]});
    run_load(0, 0, 1'b0);
    chk_lit("l12_bits", int'(obs_vec[0][11:0]), 32'hA53);
    chk_lit("l12_en_cnt", obs_en_cnt[0], 12);
    chk_lit("l12_crc_ok", int'(err_v[0]), 0);

    // Random loads with valid gaps, one with start pulsed mid-load
    for (int r = 0; r < 9; r++) begin
      int i = r % 3;
      bad = 1'(($urandom >> 3) & 1);
      build_random(i, bad);
      d = obs_done[i];
      run_load(i, 3, r == 4);
      chk_lit("rand_en_cnt", obs_en_cnt[i], cl(i));
      chk_lit("rand_crc_error", int'(err_v[i]), int'(bad));
      chk_lit("rand_done_cnt", obs_done[i], d + 1);
    end

    // Reset in the middle of a load, then a clean reload
    d = obs_done[0];
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    send_word(0, 16'h00A5, 0);
    for (int t = 0; t < 50 && obs_en_cnt[0] < 5; t++) @(negedge clk);
    @(posedge clk); #1;
    rst_v[0] = 1'b1;
    @(posedge clk); #1;
    rst_v[0] = 1'b0;
    @(negedge clk);
    chk_lit("rst_config_en", int'(cen_v[0]), 0);
    chk_lit("rst_busy", int'(busy_v[0]), 0);
    repeat (5) @(posedge clk);
    #1;
    chk_lit("rst_no_done", obs_done[0], d);
    build_random(0, 1'b0);
    run_load(0, 2, 1'b0);
    chk_lit("reload_en_cnt", obs_en_cnt[0], 12);
    chk_lit("reload_crc_ok", int'(err_v[0]), 0);

    // W=16, CL=16: single CRC word, mismatch held until the next start
    wq = '{16'h8001};
    good = crc_of_queue(16, 16);
    wq.push_back(good ^ 16'h0001);
    run_load(2, 0, 1'b0);
    chk_lit("w16_crc_bad", int'(err_v[2]), 1);
    repeat (5) @(posedge clk);
    #1;
    chk_lit("w16_err_held", int'(err_v[2]), 1);
    wq = '{16'h8001, good};
    run_load(2, 0, 1'b0);
    chk_lit("w16_crc_ok", int'(err_v[2]), 0);
    chk_lit("w16_bits", int'(obs_vec[2][15:0]), 32'h8001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
